// File: rtl/data_cache_unit.sv
// Direct-mapped, write-back, write-allocate data cache.
// 8 blocks of 4 bytes, 3-bit tag, sitting between an 8-bit CPU
// load/store port and a 32-bit block-wide data memory.
module data_cache_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  input  logic        MEM_BUSYWAIT,
  input  logic [31:0] MEM_READDATA,
  output logic [7:0]  READDATA,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        BUSYWAIT,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Per-block storage
  logic [31:0] data_reg  [0:7];
  logic [2:0]  tag_reg   [0:7];
  logic [7:0]  valid_reg;
  logic [7:0]  dirty_reg;

  state_t      state_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [5:0]  mem_address_reg;
  logic [31:0] mem_writedata_reg;

  // Address split
  logic [2:0] addr_tag;
  logic [2:0] addr_index;
  logic [1:0] addr_offset;
  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  logic hit;
  logic request;
  logic victim_dirty;
  assign hit          = valid_reg[addr_index] && (tag_reg[addr_index] == addr_tag);
  assign request      = READ | WRITE;
  assign victim_dirty = valid_reg[addr_index] && dirty_reg[addr_index];

  // Byte lanes of the indexed block, selected by the offset for loads
  logic [7:0] byte_lane [0:3];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = data_reg[addr_index][8*gi +: 8];
    end
  endgenerate

  // Combinational CPU-facing outputs; stall is forced low during reset
  always_comb begin
    READDATA = byte_lane[addr_offset];
    BUSYWAIT = RESET && request && !((state_reg == IDLE) && hit);
  end

  assign MEM_READ      = mem_read_reg;
  assign MEM_WRITE     = mem_write_reg;
  assign MEM_ADDRESS   = mem_address_reg;
  assign MEM_WRITEDATA = mem_writedata_reg;

  // Miss-handling FSM with registered memory strobes, address and data;
  // also owns all tag/valid/dirty/data updates.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg         <= IDLE;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_address_reg   <= 6'd0;
      mem_writedata_reg <= 32'd0;
      valid_reg         <= 8'd0;
      dirty_reg         <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_reg[i]  <= 3'd0;
        data_reg[i] <= 32'd0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (WRITE && hit) begin
            // Write hit: a simultaneous READ is treated as a write
            data_reg[addr_index][8*addr_offset +: 8] <= WRITEDATA;
            dirty_reg[addr_index] <= 1'b1;
          end else if (request && !hit) begin
            if (victim_dirty) begin
              state_reg         <= WRITEBACK;
              mem_write_reg     <= 1'b1;
              mem_address_reg   <= {tag_reg[addr_index], addr_index};
              mem_writedata_reg <= data_reg[addr_index];
            end else begin
              state_reg       <= FETCH;
              mem_read_reg    <= 1'b1;
              mem_address_reg <= {addr_tag, addr_index};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            // Victim accepted; move straight on to the fill
            state_reg       <= FETCH;
            mem_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b1;
            mem_address_reg <= {addr_tag, addr_index};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_reg    <= UPDATE;
            mem_read_reg <= 1'b0;
          end
        end
        UPDATE: begin
          // Memory keeps the fetched block stable while not busy
          data_reg[addr_index]  <= MEM_READDATA;
          tag_reg[addr_index]   <= addr_tag;
          valid_reg[addr_index] <= 1'b1;
          dirty_reg[addr_index] <= 1'b0;
          state_reg             <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_unit.sv
// Directed bench for data_cache_unit with a two-wait-cycle block memory model.
module tb_data_cache_unit;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic        MEM_BUSYWAIT;
  logic [31:0] MEM_READDATA;
  logic [7:0]  READDATA;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;

  data_cache_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .MEM_READDATA (MEM_READDATA),
    .READDATA     (READDATA),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: busy for the first 2 cycles of each strobe, then done
  localparam int MEM_LAT = 2;
  logic [31:0] mem [0:63];
  int          mem_cnt = 0;
  bit          mem_loaded = 1'b0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < MEM_LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  // Memory preload, busy counter and write-back capture
  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h44332211;
      mem[2] <= 32'hDDCCBBAA;
      mem[3] <= 32'h03020100;
      mem[9] <= 32'h88776655;
      mem_loaded <= 1'b1;
    end else begin
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
    if (MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
    else              mem_cnt <= 0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Per-access observations of the memory side
  bit         wb_seen;
  logic [5:0] wb_addr;
  logic [31:0] wb_data;
  bit         fe_seen;
  logic [5:0] fe_addr;
  bit         both_high;

  task automatic observe();
    if (MEM_WRITE && !wb_seen) begin
      wb_seen = 1'b1;
      wb_addr = MEM_ADDRESS;
      wb_data = MEM_WRITEDATA;
    end
    if (MEM_READ && !fe_seen) begin
      fe_seen = 1'b1;
      fe_addr = MEM_ADDRESS;
    end
    if (MEM_READ && MEM_WRITE) both_high = 1'b1;
  endtask

  // One CPU access: drive at negedge, wait (bounded) for BUSYWAIT low,
  // return load data and the number of stalled cycles.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           output logic [7:0] data, output int stalls);
    wb_seen = 0; fe_seen = 0; both_high = 0;
    wb_addr = '0; wb_data = '0; fe_addr = '0;
    stalls = 0;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    #1;
    observe();
    while (BUSYWAIT && stalls < 50) begin
      @(negedge CLK);
      #1;
      observe();
      stalls++;
    end
    check_value({tag, "_busywait_timeout"}, {31'd0, BUSYWAIT}, 32'd0);
    data = READDATA;
    // The next rising edge commits a write that has just hit
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    $display("%s: rd=%0d wr=%0d addr=0x%02h wdata=0x%02h readdata=0x%02h stalls=%0d wb=%0d fetch=%0d",
             tag, rd, wr, addr, wdata, data, stalls, wb_seen, fe_seen);
  endtask

  logic [7:0] rdata;
  int         stalls;
  int         wait_cnt;

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(negedge CLK);
    // Request during reset must not stall
    READ = 1'b1; ADDRESS = 8'h05;
    #1;
    check_value("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check_value("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check_value("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check_value("reset_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    check_value("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    $display("reset: released");

    // Cold miss: immediate stall, fetch of block 0x01
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h05;
    #1;
    check_value("cold_busywait_immediate", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    #1;
    check_value("cold_fetch_mem_read", {31'd0, MEM_READ}, 32'd1);
    check_value("cold_fetch_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check_value("cold_fetch_address", {26'd0, MEM_ADDRESS}, 32'h01);
    READ = 1'b0;
    // Let the started miss complete before re-issuing it as a full access
    wait_cnt = 0;
    while ((MEM_READ || dut.state_reg != 2'd0) && wait_cnt < 50) begin
      @(negedge CLK); #1; wait_cnt++;
    end
    check_value("cold_fill_timeout", {31'd0, MEM_READ}, 32'd0);
    do_access("cold_read", 1, 0, 8'h05, 8'h00, rdata, stalls);
    check_value("cold_readdata", {24'd0, rdata}, 32'h22);

    // Fresh cold miss from a clean reset to check the full miss penalty
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    do_access("cold_miss", 1, 0, 8'h05, 8'h00, rdata, stalls);
    check_value("cold_miss_readdata", {24'd0, rdata}, 32'h22);
    check_value("cold_miss_stalls", stalls, 32'd5);
    check_value("cold_miss_fetch_addr", {26'd0, fe_addr}, 32'h01);
    check_value("cold_miss_no_wb", {31'd0, wb_seen}, 32'd0);

    // Read hit
    do_access("read_hit", 1, 0, 8'h07, 8'h00, rdata, stalls);
    check_value("read_hit_data", {24'd0, rdata}, 32'h44);
    check_value("read_hit_stalls", stalls, 32'd0);

    // Write hit then read back
    do_access("write_hit", 0, 1, 8'h06, 8'hAB, rdata, stalls);
    check_value("write_hit_stalls", stalls, 32'd0);
    do_access("read_after_write", 1, 0, 8'h06, 8'h00, rdata, stalls);
    check_value("read_after_write_data", {24'd0, rdata}, 32'hAB);
    check_value("read_after_write_stalls", stalls, 32'd0);

    // Dirty eviction: index 1 tag 1
    do_access("dirty_evict", 1, 0, 8'h25, 8'h00, rdata, stalls);
    check_value("evict_wb_seen", {31'd0, wb_seen}, 32'd1);
    check_value("evict_wb_addr", {26'd0, wb_addr}, 32'h01);
    check_value("evict_wb_data", wb_data, 32'h44AB2211);
    check_value("evict_fetch_addr", {26'd0, fe_addr}, 32'h09);
    check_value("evict_both_high", {31'd0, both_high}, 32'd0);
    check_value("evict_stalls", stalls, 32'd8);
    check_value("evict_readdata", {24'd0, rdata}, 32'h66);
    check_value("evict_mem_updated", mem[1], 32'h44AB2211);

    // Clean miss on index 2
    do_access("clean_miss", 1, 0, 8'h08, 8'h00, rdata, stalls);
    check_value("clean_miss_no_wb", {31'd0, wb_seen}, 32'd0);
    check_value("clean_miss_fetch_addr", {26'd0, fe_addr}, 32'h02);
    check_value("clean_miss_stalls", stalls, 32'd5);
    check_value("clean_miss_readdata", {24'd0, rdata}, 32'hAA);

    // Write miss allocates, then read back
    do_access("write_miss", 0, 1, 8'h0D, 8'h5A, rdata, stalls);
    check_value("write_miss_stalls", stalls, 32'd5);
    do_access("write_miss_readback", 1, 0, 8'h0D, 8'h00, rdata, stalls);
    check_value("write_miss_readback_data", {24'd0, rdata}, 32'h5A);

    // READ and WRITE together act as a write
    do_access("read_and_write", 1, 1, 8'h0C, 8'h77, rdata, stalls);
    check_value("read_and_write_data_before", {24'd0, rdata}, 32'h00);
    do_access("read_and_write_readback", 1, 0, 8'h0C, 8'h00, rdata, stalls);
    check_value("read_and_write_readback_data", {24'd0, rdata}, 32'h77);

    // Reset in the middle of a fetch (block 1 holds clean tag 1)
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h05;
    wait_cnt = 0;
    #1;
    while (!MEM_READ && wait_cnt < 20) begin
      @(negedge CLK); #1; wait_cnt++;
    end
    check_value("midfetch_mem_read", {31'd0, MEM_READ}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check_value("midfetch_reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check_value("midfetch_reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check_value("midfetch_reset_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    $display("midfetch_reset: asserted during fetch");
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    do_access("after_reset_read", 1, 0, 8'h05, 8'h00, rdata, stalls);
    check_value("after_reset_stalls", stalls, 32'd5);
    check_value("after_reset_fetch_addr", {26'd0, fe_addr}, 32'h01);
    check_value("after_reset_readdata", {24'd0, rdata}, 32'h22);

    // Idle: no strobes without a request
    repeat (3) @(negedge CLK);
    #1;
    check_value("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
    check_value("idle_mem_write", {31'd0, MEM_WRITE}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
